seq_gen_multi: RTL and testbench

- Parametrised successor to the team's fixed 8-bit sequence generator.
- Holds a programmable table of DEPTH words of DATA_W bits and streams the first len_last+1 entries over a valid/ready interface.
- Runs in one-shot or loop mode, with a pause gate, an abort, a done pulse and a wrap counter.
- Sits between the config bus and any stream consumer; stimulus source for datapath blocks under test.

---
 rtl/seq_gen_pkg.sv | 18 +
 rtl/seq_table.sv | 34 +++
 rtl/seq_gen_multi.sv | 161 ++++++++++++++++
 tb/tb_seq_gen_multi.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the programmable sequence generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_LOOP    = 1'b1;

  // Requested last index may exceed the table; stream at most the whole table.
  function automatic int unsigned clamp_last(input int unsigned len, input int unsigned depth);
    return (len > depth - 1) ? depth - 1 : len;
  endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x DATA_W register file: async reset to a common value, one write port,
// one combinational read port.
module seq_table
  import seq_gen_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 8,
  parameter int                AW     = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] INIT_W = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT_W;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/seq_gen_multi.sv
// Programmable sequence generator: streams table[0..last] over valid/ready,
// one-shot or looping, with pause, abort, done pulse and saturating wrap count.
module seq_gen_multi
  import seq_gen_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          DEPTH    = 8,
  parameter logic [7:0]  INIT_VAL = 8'hAF,
  parameter int          CNT_W    = 16,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [AW-1:0]     len_last,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wraps
);

  localparam logic [DATA_W-1:0] INIT_W   = DATA_W'(INIT_VAL);
  localparam logic [AW:0]       LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  WRAP_MAX = '1;

  state_t              state, state_nxt;
  logic [AW-1:0]       idx, idx_nxt;
  logic [AW-1:0]       last, last_nxt;
  logic                mode_q, mode_nxt;
  logic                out_valid_nxt, done_nxt, cfg_err_nxt, busy_nxt;
  logic [DATA_W-1:0]   out_data_nxt;
  logic [CNT_W-1:0]    wraps_nxt;
  logic                wr_ok, xfer, at_last;
  logic [AW-1:0]       rd_addr;
  logic [DATA_W-1:0]   rd_data, rd_word;

  assign xfer    = out_valid && out_ready;
  assign at_last = (idx == last);
  assign wr_ok   = cfg_we && (state == IDLE) && ({1'b0, cfg_addr} <= LAST_IDX);
  assign rd_addr = (state == IDLE || at_last) ? '0 : idx + 1'b1;

  // A write landing on the same edge as start must already be visible in the first word.
  assign rd_word = (wr_ok && (cfg_addr == rd_addr)) ? cfg_wdata : rd_data;

  seq_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW),
    .INIT_W (INIT_W)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    last_nxt      = last;
    mode_nxt      = mode_q;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    wraps_nxt     = wraps;
    done_nxt      = 1'b0;
    cfg_err_nxt   = cfg_we && !wr_ok;
    if (abort) begin
      state_nxt     = IDLE;
      out_valid_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_nxt      = mode;
            last_nxt      = AW'(clamp_last(32'(len_last), DEPTH));
            idx_nxt       = '0;
            wraps_nxt     = '0;
            out_data_nxt  = rd_word;
            out_valid_nxt = 1'b1;
            state_nxt     = RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            if (at_last && (mode_q == MODE_ONESHOT)) begin
              state_nxt     = IDLE;
              out_valid_nxt = 1'b0;
              done_nxt      = 1'b1;
            end else begin
              idx_nxt      = at_last ? '0 : idx + 1'b1;
              out_data_nxt = rd_word;
              if (at_last && (wraps != WRAP_MAX)) begin
                wraps_nxt = wraps + 1'b1;
              end
              if (!enable) begin
                state_nxt     = PAUSE;
                out_valid_nxt = 1'b0;
              end
            end
          end
        end
        PAUSE: begin
          if (enable) begin
            state_nxt     = RUN;
            out_valid_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
        end
      endcase
    end
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      last      <= '0;
      mode_q    <= MODE_ONESHOT;
      out_valid <= 1'b0;
      out_data  <= INIT_W;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      wraps     <= '0;
    end else begin
      idx       <= idx_nxt;
      last      <= last_nxt;
      mode_q    <= mode_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cfg_err   <= cfg_err_nxt;
      wraps     <= wraps_nxt;
    end
  end

endmodule

// File: tb/tb_seq_gen_multi.sv
// Scoreboard bench for seq_gen_multi (DEPTH=6 to exercise out-of-range writes, CNT_W=3 for saturation).
module tb_seq_gen_multi;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 6;
  localparam int CNT_W  = 3;
  localparam int AW     = 3;
  localparam logic [7:0] INIT = 8'hAF;

  logic clk = 1'b0;
  logic rst, enable, start, abort, mode, cfg_we, cfg_err;
  logic out_valid, out_ready, busy, done;
  logic [AW-1:0]     len_last, cfg_addr;
  logic [DATA_W-1:0] cfg_wdata, out_data;
  logic [CNT_W-1:0]  wraps;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model[DEPTH];
  logic [DATA_W-1:0] e;

  always #5 clk = ~clk;

  seq_gen_multi #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_VAL (INIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .len_last  (len_last),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .wraps     (wraps)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    len_last = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;
    tick; tick;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: valid=%b busy=%b done=%b err=%b, required all 0", out_valid, busy, done, cfg_err);
    end
    total++;
    if (wraps !== '0) begin bad++; $display("FAIL reset_wraps: got %0d, required 0", wraps); end
    total++;
    if (out_data !== INIT) begin bad++; $display("FAIL reset_data: got %h, required %h", out_data, INIT); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_oneshot_default;
    exp_q.delete();
    mode = 1'b0; len_last = 3'd3; start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
    tick;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL os_valid c=%0d: valid=%b, required 1", c, out_valid);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin bad++; $display("FAIL os_data c=%0d: got %h, required %h", c, out_data, e); end
      end
      tick;
    end
    total++;
    if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL os_end: valid=%b done=%b busy=%b, required 0/1/0", out_valid, done, busy);
    end
    total++;
    if (wraps !== '0) begin bad++; $display("FAIL os_wraps: got %0d, required 0", wraps); end
    tick;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL os_done_pulse: done=%b one cycle later, required 0", done); end
  endtask

  task automatic test_handshake;
    int dones;
    dones = 0;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_wdata = 8'(17 * (i + 1)); model[i] = cfg_wdata;
      tick;
      total++;
      if (cfg_err !== 1'b0) begin bad++; $display("FAIL hs_cfg_err i=%0d: got %b, required 0", i, cfg_err); end
    end
    // Entry 0 is written on the same edge as start.
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'h11; model[0] = 8'h11;
    mode = 1'b0; len_last = 3'd3; start = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
    tick;
    cfg_we = 1'b0; start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      out_ready = (c % 2 == 0);
      if (done) dones++;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL hs_extra c=%0d: got word %h, required none", c, out_data);
        end else begin
          if (out_data !== exp_q[0]) begin bad++; $display("FAIL hs_data c=%0d: got %h, required %h", c, out_data, exp_q[0]); end
          if (out_ready) e = exp_q.pop_front();
        end
      end
      tick;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL hs_count: %0d words missing, required 0", exp_q.size()); end
    total++;
    if (dones != 1) begin bad++; $display("FAIL hs_done: %0d pulses, required 1", dones); end
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h44) begin
      bad++; $display("FAIL hs_hold: valid=%b data=%h, required 0/44", out_valid, out_data);
    end
  endtask

  task automatic test_loop;
    int dones;
    dones = 0;
    exp_q.delete();
    out_ready = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'hA5; model[0] = 8'hA5; tick;
    cfg_addr = 3'd1; cfg_wdata = 8'h5A; model[1] = 8'h5A; tick;
    cfg_we = 1'b0;
    mode = 1'b1; len_last = 3'd1; start = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(model[i % 2]);
    tick;
    start = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (done) dones++;
      total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL loop_valid c=%0d: valid=%b, required 1", c, out_valid);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin bad++; $display("FAIL loop_data c=%0d: got %h, required %h", c, out_data, e); end
      end
      tick;
    end
    total++;
    if (wraps !== 3'd5) begin bad++; $display("FAIL loop_wraps: got %0d, required 5", wraps); end
    total++;
    if (dones != 0 || busy !== 1'b1) begin bad++; $display("FAIL loop_done: dones=%0d busy=%b, required 0/1", dones, busy); end
    out_ready = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_pause;
    logic exp_v;
    exp_q.delete();
    mode = 1'b1; len_last = 3'd3; start = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(model[i % 4]);
    tick;
    start = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      enable = (c == 0 || c >= 5);
      exp_v  = !(c >= 2 && c <= 5);
      total++;
      if (out_valid !== exp_v) begin bad++; $display("FAIL pause_valid c=%0d: got %b, required %b", c, out_valid, exp_v); end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if (out_data !== e) begin bad++; $display("FAIL pause_data c=%0d: got %h, required %h", c, out_data, e); end
      end
      tick;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL pause_count: %0d words missing, required 0", exp_q.size()); end
    enable = 1'b1; out_ready = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_cfg_err;
    int dones;
    dones = 0;
    exp_q.delete();
    out_ready = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd6; cfg_wdata = 8'hEE;
    tick;
    cfg_we = 1'b0;
    total++;
    if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_range: got %b, required 1", cfg_err); end
    tick;
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_pulse: got %b, required 0", cfg_err); end
    mode = 1'b0; len_last = 3'd7; start = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(model[i]);
    tick;
    start = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'h99;
    tick;
    cfg_we = 1'b0;
    total++;
    if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_run: got %b, required 1", cfg_err); end
    total++;
    if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
      bad++; $display("FAIL err_hold: valid=%b data=%h, required 1/%h", out_valid, out_data, exp_q[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done) dones++;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL err_extra c=%0d: got word %h, required none", c, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin bad++; $display("FAIL err_readback c=%0d: got %h, required %h", c, out_data, e); end
        end
      end
      tick;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL err_count: %0d words missing, required 0", exp_q.size()); end
    total++;
    if (dones != 1) begin bad++; $display("FAIL err_done: %0d pulses, required 1", dones); end
  endtask

  task automatic test_abort;
    int dones;
    dones = 0;
    exp_q.delete();
    mode = 1'b0; len_last = 3'd3; start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
    tick;
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      abort = (c == 1);
      e = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        bad++; $display("FAIL abort_word c=%0d: valid=%b data=%h, required 1/%h", c, out_valid, out_data, e);
      end
      tick;
    end
    abort = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle: valid=%b busy=%b done=%b, required 0/0/0", out_valid, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      if (done) dones++;
      tick;
    end
    total++;
    if (dones != 0) begin bad++; $display("FAIL abort_done: %0d pulses, required 0", dones); end
    exp_q.delete();
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_over_start: valid=%b busy=%b, required 0/0", out_valid, busy);
    end
  endtask

  task automatic test_len0;
    exp_q.delete();
    mode = 1'b0; len_last = 3'd0; start = 1'b1; out_ready = 1'b1;
    tick;
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== model[0]) begin
      bad++; $display("FAIL len0_word: valid=%b data=%h, required 1/%h", out_valid, out_data, model[0]);
    end
    tick;
    total++;
    if (out_valid !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL len0_done: valid=%b done=%b, required 0/1", out_valid, done);
    end
    mode = 1'b1; start = 1'b1;
    for (int i = 0; i < 9; i++) exp_q.push_back(model[0]);
    tick;
    start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c == 3) begin
        total++;
        if (wraps !== 3'd3) begin bad++; $display("FAIL len0_wraps: got %0d, required 3", wraps); end
      end
      e = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        bad++; $display("FAIL len0_loop c=%0d: valid=%b data=%h, required 1/%h", c, out_valid, out_data, e);
      end
      tick;
    end
    total++;
    if (wraps !== 3'd7) begin bad++; $display("FAIL len0_sat: got %0d, required 7", wraps); end
    out_ready = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid;
    exp_q.delete();
    mode = 1'b1; len_last = 3'd1; start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(model[i % 2]);
    tick;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      e = exp_q.pop_front();
      total++;
      if (out_data !== e) begin bad++; $display("FAIL rmid_data c=%0d: got %h, required %h", c, out_data, e); end
      tick;
    end
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wraps !== '0 || out_data !== INIT) begin
      bad++; $display("FAIL rmid_reset: valid=%b busy=%b done=%b wraps=%0d data=%h, required 0/0/0/0/%h",
                      out_valid, busy, done, wraps, out_data, INIT);
    end
    tick;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;
    tick;
    mode = 1'b0; len_last = 3'd1; start = 1'b1;
    for (int i = 0; i < 2; i++) exp_q.push_back(model[i]);
    tick;
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      e = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        bad++; $display("FAIL rmid_restart c=%0d: valid=%b data=%h, required 1/%h", c, out_valid, out_data, e);
      end
      tick;
    end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL rmid_done: got %b, required 1", done); end
  endtask

  initial begin
    test_reset;
    test_oneshot_default;
    test_handshake;
    test_loop;
    test_pause;
    test_cfg_err;
    test_abort;
    test_len0;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
